jk_step_ctrl: RTL and testbench

Step-sequencing controller for a WIDTH-bit register bank built from the team's `jkff` cells (synchronous reset, J/K with hold/reset/set/toggle). It derives every cell's J/K excitation each cycle to hold, parallel-load, or count up/down. A start/busy/done handshake runs the bank for a requested number of steps. It sits between lab sequencing logic (or switches/debouncers) and the flip-flop bank, which it owns.

---
 rtl/jk_step_pkg.sv | 31 +++
 rtl/jkff.sv | 36 +++
 rtl/jk_step_ctrl.sv | 119 +++++++++++
 tb/tb_jk_step_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/jk_step_pkg.sv
// Shared types and constants for the jk_step_ctrl block: FSM encoding and
// the J/K excitation pairs used to drive the flip-flop bank.
package jk_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  localparam jk_t JK_HOLD = 2'b00;
  localparam jk_t JK_CLR  = 2'b01;
  localparam jk_t JK_SET  = 2'b10;
  localparam jk_t JK_TOG  = 2'b11;

  // Excitation that makes a cell settle at the given value on the next edge.
  function automatic jk_t jk_for_value(input logic v);
    jk_for_value = v ? JK_SET : JK_CLR;
  endfunction

  // Excitation that toggles a cell when en is set and holds it otherwise.
  function automatic jk_t jk_for_toggle(input logic en);
    jk_for_toggle = en ? JK_TOG : JK_HOLD;
  endfunction

endpackage

// File: rtl/jkff.sv
// Single J/K flip-flop cell with synchronous active-high reset.
module jkff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next-state function: hold, reset, set or toggle.
  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Cell storage; reset clears the cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_step_ctrl.sv
// Step-sequencing controller: owns a bank of jkff cells and derives their
// J/K excitation to hold, parallel-load, or count up/down for a requested
// number of steps under a start/busy/done handshake.
module jk_step_ctrl
  import jk_step_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] steps,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] remaining_d;
  logic             dir_q;
  logic             dir_d;
  logic [WIDTH-1:0] tog_en_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;

  // Counting enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic carry;
    carry    = 1'b1;
    tog_en_s = CNT_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      tog_en_s[i] = carry;
      carry       = carry & (dir_q ? q[i] : ~q[i]);
    end
  end

  // FSM next state, step counter, direction latch and per-bit excitation mux.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    j_s         = CNT_ZERO;
    k_s         = CNT_ZERO;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          // Load wins over start; the start request is dropped.
          for (int i = 0; i < WIDTH; i++) begin
            {j_s[i], k_s[i]} = jk_for_value(load_val[i]);
          end
        end else if (start) begin
          dir_d       = dir;
          remaining_d = steps;
          if (steps != CNT_ZERO) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < WIDTH; i++) begin
          {j_s[i], k_s[i]} = jk_for_toggle(tog_en_s[i]);
        end
        remaining_d = remaining_q - CNT_ONE;
        if (remaining_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= CNT_ZERO;
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jkff u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_s[g]),
      .k     (k_s[g]),
      .q     (q[g])
    );
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign tc   = dir_q ? (&q) : ~(|q);

endmodule

// File: tb/tb_jk_step_ctrl.sv
// Directed self-checking bench for jk_step_ctrl (WIDTH = 4).
module tb_jk_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dir;
  logic [3:0] steps;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       tc;

  int n_vec  = 0;
  int n_miss = 0;

  jk_step_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .steps    (steps),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eq, input logic eb,
                            input logic ed, input logic et);
    chk({tag, ".q"}, {28'd0, q}, {28'd0, eq});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".tc"}, {31'd0, tc}, {31'd0, et});
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b1; steps = 4'd0;
    load = 1'b0; load_val = 4'd0;
    tick(); tick();
    expect_out("rst", 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // Load A, count up 3 steps.
    load = 1'b1; load_val = 4'hA;
    tick();
    load = 1'b0;
    expect_out("ldA", 4'hA, 1'b0, 1'b0, 1'b0);
    start = 1'b1; dir = 1'b1; steps = 4'd3;
    tick();
    start = 1'b0;
    expect_out("up.e0", 4'hA, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("up.e1", 4'hB, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("up.e2", 4'hC, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("up.e3", 4'hD, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("up.end", 4'hD, 1'b0, 1'b0, 1'b0);

    // Load 1, count down 3 steps through zero.
    load = 1'b1; load_val = 4'h1;
    tick();
    load = 1'b0;
    expect_out("ld1", 4'h1, 1'b0, 1'b0, 1'b0);
    start = 1'b1; dir = 1'b0; steps = 4'd3;
    tick();
    start = 1'b0;
    expect_out("dn.e0", 4'h1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("dn.e1", 4'h0, 1'b1, 1'b0, 1'b1);
    tick(); expect_out("dn.e2", 4'hF, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("dn.e3", 4'hE, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("dn.end", 4'hE, 1'b0, 1'b0, 1'b0);

    // Zero-step run: straight to DONE.
    start = 1'b1; dir = 1'b0; steps = 4'd0;
    tick();
    start = 1'b0;
    expect_out("z.e0", 4'hE, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("z.end", 4'hE, 1'b0, 1'b0, 1'b0);

    // Five-step up run with ignored start/load mid-run.
    start = 1'b1; dir = 1'b1; steps = 4'd5;
    tick();
    start = 1'b0;
    expect_out("ig.e0", 4'hE, 1'b1, 1'b0, 1'b0);
    start = 1'b1; load = 1'b1; load_val = 4'h7; steps = 4'd2; dir = 1'b0;
    tick();
    start = 1'b0; load = 1'b0;
    expect_out("ig.e1", 4'hF, 1'b1, 1'b0, 1'b1);
    tick(); expect_out("ig.e2", 4'h0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ig.e3", 4'h1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ig.e4", 4'h2, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ig.e5", 4'h3, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("ig.end", 4'h3, 1'b0, 1'b0, 1'b0);

    // Reset mid-run at E2 of a six-step run.
    start = 1'b1; dir = 1'b1; steps = 4'd6;
    tick();
    start = 1'b0;
    tick(); expect_out("ab.e1", 4'h4, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("ab.e2", 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("ab.post", 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // Load and start together: load wins, no run.
    load = 1'b1; start = 1'b1; load_val = 4'h9; dir = 1'b0; steps = 4'd2;
    tick();
    load = 1'b0; start = 1'b0;
    expect_out("ls.e0", 4'h9, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("ls.e1", 4'h9, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("ls.e2", 4'h9, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
